// File: rtl/rnn_step_engine.sv
// One Elman-style RNN time step: h'[j] = act(sat16((b[j] + x.W[:,j] + h.U[:,j]) >>> FRAC)).
// Operands are fetched one per cycle through combinational read ports; h is committed atomically.
module rnn_step_engine #(
    parameter int X_LEN = 2,
    parameter int H_LEN = 4,
    parameter int FRAC  = 0,
    parameter int RELU  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clear_h,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                x_idx,
    input  logic signed [15:0]        x_data,
    output logic [7:0]                w_row,
    output logic [7:0]                w_col,
    input  logic signed [15:0]        w_data,
    output logic [7:0]                u_row,
    output logic [7:0]                u_col,
    input  logic signed [15:0]        u_data,
    output logic [7:0]                b_idx,
    input  logic signed [15:0]        b_data,
    output logic [16*H_LEN-1:0]       h_out
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = 40;
    localparam int IDX_W  = (H_LEN > 1) ? $clog2(H_LEN) : 1;
    localparam logic [7:0] X_LAST = 8'(X_LEN - 1);
    localparam logic [7:0] H_LAST = 8'(H_LEN - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

    typedef enum logic [2:0] {IDLE, BIAS, XW, HU, WB, COMMIT} state_t;

    state_t                    state_q, state_d;
    logic [7:0]                col_q;
    logic [7:0]                cnt_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DATA_W-1:0]  h_q      [H_LEN];
    logic signed [DATA_W-1:0]  h_next_q [H_LEN];
    logic signed [PROD_W-1:0]  prod_xw;
    logic signed [PROD_W-1:0]  prod_hu;
    logic signed [DATA_W-1:0]  h_sel;
    logic signed [DATA_W-1:0]  wb_val;

    function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)      return 16'sh7fff;
        else if (v < SAT_MIN) return 16'sh8000;
        else                  return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] act(input logic signed [DATA_W-1:0] v);
        if (RELU != 0 && v < 0) return '0;
        else                    return v;
    endfunction

    // The recurrent operand always comes from the committed state, never from h_next.
    assign h_sel   = h_q[cnt_q[IDX_W-1:0]];
    assign prod_xw = PROD_W'(x_data) * PROD_W'(w_data);
    assign prod_hu = PROD_W'(h_sel) * PROD_W'(u_data);
    assign wb_val  = act(sat16(acc_q >>> FRAC));

    for (genvar g = 0; g < H_LEN; g++) begin : g_hout
        assign h_out[16*g +: 16] = h_q[g];
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        x_idx   = '0;
        w_row   = '0;
        w_col   = '0;
        u_row   = '0;
        u_col   = '0;
        b_idx   = '0;
        case (state_q)
            IDLE:   if (start) state_d = BIAS;
            BIAS: begin
                b_idx   = col_q;
                state_d = XW;
            end
            XW: begin
                x_idx = cnt_q;
                w_row = cnt_q;
                w_col = col_q;
                if (cnt_q == X_LAST) state_d = HU;
            end
            HU: begin
                u_row = cnt_q;
                u_col = col_q;
                if (cnt_q == H_LAST) state_d = WB;
            end
            WB:     state_d = (col_q == H_LAST) ? COMMIT : BIAS;
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            done    <= 1'b0;
            for (int n = 0; n < H_LEN; n++) begin
                h_q[n]      <= '0;
                h_next_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear_h) begin
                        for (int n = 0; n < H_LEN; n++) h_q[n] <= '0;
                    end
                    if (start) begin
                        col_q <= '0;
                        cnt_q <= '0;
                    end
                end
                BIAS: begin
                    acc_q <= ACC_W'(b_data);
                    cnt_q <= '0;
                end
                XW: begin
                    acc_q <= acc_q + ACC_W'(prod_xw);
                    cnt_q <= (cnt_q == X_LAST) ? 8'd0 : cnt_q + 8'd1;
                end
                HU: begin
                    acc_q <= acc_q + ACC_W'(prod_hu);
                    cnt_q <= (cnt_q == H_LAST) ? 8'd0 : cnt_q + 8'd1;
                end
                WB: begin
                    h_next_q[col_q[IDX_W-1:0]] <= wb_val;
                    col_q <= (col_q == H_LAST) ? 8'd0 : col_q + 8'd1;
                end
                COMMIT: begin
                    h_q  <= h_next_q;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
